// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_queue
//  Purpose  : Instruction-fetch front end. Issues sequential fetch addresses
//             to instruction memory, buffers returned instructions in a small
//             in-order queue and presents pc/instr pairs to the ID stage.
//             A redirect flushes the queue, restarts fetch at a new PC and
//             discards responses that belong to pre-redirect requests.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk               in   1     clock, rising edge
//    rst_n             in   1     synchronous active-low reset
//    redirect_i        in   1     flush and restart fetch at redirect_pc_i
//    redirect_pc_i     in   XLEN  new fetch PC (bits [1:0] ignored)
//    imem_req_valid_o  out  1     fetch request valid
//    imem_req_ready_i  in   1     memory accepts request
//    imem_req_addr_o   out  XLEN  fetch address
//    imem_rsp_valid_i  in   1     instruction returned (in request order)
//    imem_rsp_data_i   in   32    returned instruction
//    id_valid_o        out  1     queue head valid toward ID
//    id_ready_i        in   1     ID accepts head
//    id_pc_o           out  XLEN  PC of head entry
//    id_instr_o        out  32    instruction of head entry
// ============================================================================
module if_fetch_queue #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_instr_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // One extra bit so q_cnt + out_cnt can never overflow the compare.
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t          state_q,    state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q,   rsp_pc_d;
  logic [CW-1:0]   q_cnt_q,    q_cnt_d;
  logic [CW-1:0]   out_cnt_q,  out_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]   head_q,     head_d;
  logic [AW-1:0]   tail_q,     tail_d;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic [XLEN-1:0] redirect_pc_al;
  logic [CW:0]     inflight;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_take;
  logic            rsp_drop;
  logic            push;
  logic            id_valid;
  logic            pop;

  // Low two bits are forced to zero: fetch is always word aligned.
  assign redirect_pc_al = redirect_pc_i & ~XLEN'(3);

  // Queued plus outstanding entries are capped at DEPTH, so every response
  // is guaranteed a free slot when it arrives.
  assign inflight  = {1'b0, q_cnt_q} + {1'b0, out_cnt_q};
  assign req_valid = rst_n && (state_q == ST_RUN) && !redirect_i && (inflight < DEPTH_W);
  assign req_fire  = req_valid && imem_req_ready_i;

  // A response with nothing outstanding is a protocol violation; ignore it.
  assign rsp_take  = imem_rsp_valid_i && (out_cnt_q != '0);
  assign rsp_drop  = rsp_take && (drop_cnt_q != '0);
  assign push      = rsp_take && (drop_cnt_q == '0) && !redirect_i;

  assign id_valid  = rst_n && (q_cnt_q != '0) && !redirect_i;
  assign pop       = id_valid && id_ready_i;

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = fetch_pc_q;
  assign id_valid_o       = id_valid;
  assign id_pc_o          = id_valid ? pc_mem[head_q]    : '0;
  assign id_instr_o       = id_valid ? instr_mem[head_q] : '0;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    q_cnt_d    = q_cnt_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    case ({req_fire, rsp_take})
      2'b10:   out_cnt_d = out_cnt_q + CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end else if (rsp_take) begin
      rsp_pc_d = rsp_pc_q + XLEN'(4);
    end

    if (push) begin
      tail_d = tail_q + AW'(1);
    end
    if (pop) begin
      head_d = head_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   q_cnt_d = q_cnt_q + CW'(1);
      2'b01:   q_cnt_d = q_cnt_q - CW'(1);
      default: q_cnt_d = q_cnt_q;
    endcase

    // Leave DRAIN once the last stale response has been consumed.
    if ((state_q == ST_DRAIN) && (drop_cnt_d == '0)) begin
      state_d = ST_RUN;
    end

    // Redirect overrides everything. No request can fire this cycle, so the
    // outstanding count after this edge is exactly what must be discarded;
    // in DRAIN this equals the remaining drop count anyway.
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_al;
      rsp_pc_d   = redirect_pc_al;
      q_cnt_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_cnt_d = out_cnt_d;
      state_d    = (out_cnt_d != '0) ? ST_DRAIN : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      q_cnt_q    <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      q_cnt_q    <= q_cnt_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Queue storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]    <= rsp_pc_q;
      instr_mem[tail_q] <= imem_rsp_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_queue
//  Purpose  : Self-checking bench for if_fetch_queue with an in-order
//             instruction-memory model and a pc/instr scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

  localparam int          XLEN     = 64;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            redirect_i = 1'b0;
  logic [XLEN-1:0] redirect_pc_i = '0;
  logic            imem_req_valid_o;
  logic            imem_req_ready_i = 1'b1;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_rsp_valid_i = 1'b0;
  logic [31:0]     imem_rsp_data_i = '0;
  logic            id_valid_o;
  logic            id_ready_i = 1'b1;
  logic [XLEN-1:0] id_pc_o;
  logic [31:0]     id_instr_o;

  if_fetch_queue #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_pc_o          (id_pc_o),
    .id_instr_o       (id_instr_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] ins; } exp_t;
  typedef struct { logic [63:0] addr; int due; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [63:0] exp_fetch = RESET_PC;
  int          cyc = 0;
  int          lat = 1;
  bit          rnd_mem = 0;
  bit          rnd_id  = 0;
  int          bench_out = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  // Values sampled one time unit before the active edge by step().
  bit          s_req_valid, s_req_fire, s_pop, s_rsp;
  logic [63:0] s_req_addr, s_pop_pc;
  int          s_cyc;

  function automatic logic [31:0] instr_of(logic [63:0] a);
    return (a[31:0] << 5) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  // One clock cycle: sample/score just before the edge, then let the memory
  // model drive the response for the next cycle after the falling edge.
  task automatic step();
    exp_t  e;
    pend_t p;
    #4;
    s_cyc       = cyc;
    s_req_valid = imem_req_valid_o;
    s_req_fire  = imem_req_valid_o && imem_req_ready_i;
    s_req_addr  = imem_req_addr_o;
    s_pop       = id_valid_o && id_ready_i;
    s_pop_pc    = id_pc_o;
    s_rsp       = imem_rsp_valid_i;
    if (!rst_n) begin
      exp_q.delete();
      pend_q.delete();
      exp_fetch = RESET_PC;
      bench_out = 0;
    end else begin
      if (redirect_i) begin
        n_vec++;
        if (imem_req_valid_o !== 1'b0 || id_valid_o !== 1'b0) begin
          n_bad++;
          $display("FAIL redirect_mask: req_valid=%b id_valid=%b, required 0 0", imem_req_valid_o, id_valid_o);
        end
      end
      if (s_rsp) begin
        n_vec++;
        assert (bench_out > 0) else begin
          n_bad++;
          $display("FAIL rsp_protocol: response with %0d outstanding, required >0", bench_out);
        end
        if (bench_out > 0) bench_out--;
      end
      if (s_req_fire) begin
        n_vec++;
        if (imem_req_addr_o !== exp_fetch) begin
          n_bad++;
          $display("FAIL req_addr: got %h required %h", imem_req_addr_o, exp_fetch);
        end
        p.addr = imem_req_addr_o;
        p.due  = cyc + lat;
        pend_q.push_back(p);
        e.pc  = exp_fetch;
        e.ins = instr_of(exp_fetch);
        exp_q.push_back(e);
        exp_fetch = exp_fetch + 64'd4;
        bench_out++;
      end
      if (s_pop) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL id_pop: unexpected pop pc=%h, required no valid head", id_pc_o);
        end else begin
          e = exp_q.pop_front();
          if (id_pc_o !== e.pc || id_instr_o !== e.ins) begin
            n_bad++;
            $display("FAIL id_data: got pc=%h instr=%h required pc=%h instr=%h", id_pc_o, id_instr_o, e.pc, e.ins);
          end
        end
      end
      if (redirect_i) begin
        exp_q.delete();
        exp_fetch = {redirect_pc_i[63:2], 2'b00};
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    if (rst_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = instr_of(p.addr);
    end
    imem_req_ready_i = rnd_mem ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rnd_id) id_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0; redirect_i = 1'b0; id_ready_i = 1'b1;
    rnd_mem = 0; rnd_id = 0; lat = l;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lat = 1;
    step(); step();
    n_vec++;
    if (imem_req_valid_o !== 1'b0 || id_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid: req_valid=%b id_valid=%b required 0 0", imem_req_valid_o, id_valid_o);
    end
    n_vec++;
    if (imem_req_addr_o !== RESET_PC || id_pc_o !== 64'd0 || id_instr_o !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_values: addr=%h id_pc=%h id_instr=%h required %h 0 0", imem_req_addr_o, id_pc_o, id_instr_o, RESET_PC);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== RESET_PC) begin
      n_bad++;
      $display("FAIL reset_release: valid=%b addr=%h required 1 %h", imem_req_valid_o, imem_req_addr_o, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int first_pop = -1;
    int pops = 0;
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_pop) begin
        pops++;
        if (first_pop < 0) first_pop = i;
      end
    end
    n_vec++;
    if (first_pop != 2) begin
      n_bad++;
      $display("FAIL stream_first_pop: got cycle %0d required 2", first_pop);
    end
    n_vec++;
    if (pops != 18) begin
      n_bad++;
      $display("FAIL stream_throughput: got %0d pops required 18", pops);
    end
  endtask

  task automatic test_stall();
    int reqs = 0;
    do_reset(1);
    id_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_req_fire) reqs++;
    end
    n_vec++;
    if (reqs != DEPTH || imem_req_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_requests: got %0d reqs valid=%b required %0d 0", reqs, imem_req_valid_o, DEPTH);
    end
    n_vec++;
    if (id_valid_o !== 1'b1 || id_pc_o !== RESET_PC) begin
      n_bad++;
      $display("FAIL stall_head: valid=%b pc=%h required 1 %h", id_valid_o, id_pc_o, RESET_PC);
    end
    id_ready_i = 1'b1;
    step();
    step();
    n_vec++;
    if (!s_req_valid || !s_pop) begin
      n_bad++;
      $display("FAIL stall_refill: req_valid=%b pop=%b required 1 1", s_req_valid, s_pop);
    end
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_redirect_drain();
    bit found = 0;
    do_reset(3);
    step(); step();
    redirect_i = 1'b1; redirect_pc_i = 64'h8000_0100;
    step();
    redirect_i = 1'b0;
    step();
    n_vec++;
    if (s_req_valid || !s_rsp) begin
      n_bad++;
      $display("FAIL drain_1: req_valid=%b rsp=%b required 0 1", s_req_valid, s_rsp);
    end
    step();
    n_vec++;
    if (s_req_valid || !s_rsp) begin
      n_bad++;
      $display("FAIL drain_2: req_valid=%b rsp=%b required 0 1", s_req_valid, s_rsp);
    end
    step();
    n_vec++;
    if (!s_req_fire || s_req_addr !== 64'h8000_0100) begin
      n_bad++;
      $display("FAIL drain_resume: fire=%b addr=%h required 1 8000_0100", s_req_fire, s_req_addr);
    end
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (s_pop) begin
        found = 1;
        n_vec++;
        if (s_pop_pc !== 64'h8000_0100) begin
          n_bad++;
          $display("FAIL drain_first_id: got %h required 8000_0100", s_pop_pc);
        end
      end
    end
    if (!found) begin
      n_vec++; n_bad++;
      $display("FAIL drain_first_id: no ID pop within bound, required pc 8000_0100");
    end
  endtask

  task automatic test_redirect_collision();
    bit found = 0;
    int n_after, rcyc, last_rsp, resume;
    do_reset(2);
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (imem_rsp_valid_i && id_valid_o) found = 1;
    end
    n_vec++;
    if (!found) begin
      n_bad++;
      $display("FAIL collide_setup: got no push+pop cycle, required one");
    end
    redirect_i = 1'b1; redirect_pc_i = 64'h8000_1000;
    n_after = pend_q.size();
    rcyc = cyc;
    step();
    redirect_i = 1'b0;
    n_vec++;
    if (id_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL collide_empty: id_valid=%b required 0", id_valid_o);
    end
    last_rsp = -1; resume = -1;
    for (int i = 0; i < 20 && resume < 0; i++) begin
      step();
      if (s_req_valid) resume = s_cyc;
      else if (s_rsp) last_rsp = s_cyc;
    end
    n_vec++;
    if (resume != ((n_after > 0) ? last_rsp + 1 : rcyc + 1)) begin
      n_bad++;
      $display("FAIL collide_resume: got cycle %0d required %0d", resume, (n_after > 0) ? last_rsp + 1 : rcyc + 1);
    end
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_drain_redirect_wrap();
    int fires = 0;
    logic [63:0] a0, a1;
    do_reset(3);
    step(); step();
    redirect_i = 1'b1; redirect_pc_i = 64'h8000_0100;
    step();
    redirect_pc_i = 64'h8000_0203;
    step();
    redirect_i = 1'b0;
    for (int i = 0; i < 10 && fires == 0; i++) begin
      step();
      if (s_req_fire) begin fires = 1; a0 = s_req_addr; end
    end
    n_vec++;
    if (fires == 0 || a0 !== 64'h8000_0200) begin
      n_bad++;
      $display("FAIL drain_redirect: got fire=%0d addr=%h required 1 8000_0200", fires, a0);
    end
    redirect_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_i = 1'b0;
    fires = 0;
    for (int i = 0; i < 30 && fires < 2; i++) begin
      step();
      if (s_req_fire) begin
        if (fires == 0) a0 = s_req_addr; else a1 = s_req_addr;
        fires++;
      end
    end
    n_vec++;
    if (fires < 2 || a0 !== 64'hFFFF_FFFF_FFFF_FFFC || a1 !== 64'd0) begin
      n_bad++;
      $display("FAIL wrap: got %0d fires %h %h required FFFFFFFFFFFFFFFC 0", fires, a0, a1);
    end
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_full_push_pop();
    bit both = 0;
    do_reset(3);
    id_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
    id_ready_i = 1'b1;
    step();
    both = s_pop && s_rsp;
    n_vec++;
    if (!both || s_pop_pc !== RESET_PC) begin
      n_bad++;
      $display("FAIL full_push_pop: pop=%b rsp=%b pc=%h required 1 1 %h", s_pop, s_rsp, s_pop_pc, RESET_PC);
    end
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    rnd_mem = 1; rnd_id = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        redirect_i = 1'b1;
        redirect_pc_i = {32'h8000_0000, 32'($urandom)};
      end
      if (i == 120) rst_n = 1'b0;
      step();
      redirect_i = 1'b0;
      if (i == 120) begin
        n_vec++;
        if (id_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0 || imem_req_addr_o !== RESET_PC) begin
          n_bad++;
          $display("FAIL mid_reset: id_valid=%b req_valid=%b addr=%h required 0 0 %h", id_valid_o, imem_req_valid_o, imem_req_addr_o, RESET_PC);
        end
        rst_n = 1'b1;
      end
    end
    rnd_mem = 0; rnd_id = 0; id_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_redirect_collision();
    test_drain_redirect_wrap();
    test_full_push_pop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
